s84_sched: RTL and testbench

- Shares one combinational s84 ALU instance between NREQ requesters.
- Arbitrates round-robin, registers operands into the ALU, waits SETTLE cycles, captures C/Y/Z and returns them to the winning requester with a valid/ready handshake.
- Sits between requester blocks and the single s84 instance; the s84 instance lives at the parent level.

---
 rtl/s84_pkg.sv | 20 ++
 rtl/s84_rr_arb.sv | 26 ++
 rtl/s84_sched.sv | 159 +++++++++++++++
 tb/tb_s84_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s84_pkg.sv
// Shared types and widths for the s84 ALU and its request scheduler.
package s84_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int A_W     = 8;
    localparam int B_W     = 4;
    localparam int Y_W     = 8;
    localparam int Z_W     = 4;
    localparam int FLOC_W  = 3;
    localparam int FTYPE_W = 2;

    localparam logic OP_SQM = 1'b0;
    localparam logic OP_CA2 = 1'b1;

endpackage

// File: rtl/s84_rr_arb.sv
// Combinational round-robin pick: first asserted request after last_grant, wrapping modulo NREQ.
module s84_rr_arb
    import s84_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last_grant,
    output logic [1:0]      winner,
    output logic            any_req
);

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!any_req && req[j] && (j == (32'(last_grant) + off) % NREQ)) begin
                    winner  = j[1:0];
                    any_req = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/s84_sched.sv
// Time-shares one combinational s84 ALU between NREQ requesters: round-robin accept,
// hold operands for SETTLE cycles, capture C/Y/Z and hand them back with valid/ready.
module s84_sched
    import s84_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*A_W-1:0]       req_a,
    input  logic [NREQ*B_W-1:0]       req_b,
    input  logic [NREQ-1:0]           req_op,
    input  logic [NREQ*FLOC_W-1:0]    req_f_loc,
    input  logic [NREQ*FTYPE_W-1:0]   req_f_type,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [A_W-1:0]            rsp_c,
    output logic [Y_W-1:0]            rsp_y,
    output logic [Z_W-1:0]            rsp_z,
    output logic [A_W-1:0]            alu_a,
    output logic [B_W-1:0]            alu_b,
    output logic                      alu_op,
    output logic [FLOC_W-1:0]         alu_f_loc,
    output logic [FTYPE_W-1:0]        alu_f_type,
    input  logic [A_W-1:0]            alu_c,
    input  logic [Y_W-1:0]            alu_y,
    input  logic [Z_W-1:0]            alu_z,
    output logic                      busy,
    output logic [1:0]                grant_id,
    output logic [15:0]               ops_done
);

    state_t state, state_nxt;

    logic [2:0]         cnt;
    logic [1:0]         last_grant;
    logic [1:0]         winner;
    logic               any_req;
    logic               accept, capture, done;
    logic [15:0]        ops_cnt;
    logic [NREQ-1:0]    win_oh, grant_oh;

    logic [A_W-1:0]     sel_a;
    logic [B_W-1:0]     sel_b;
    logic               sel_op;
    logic [FLOC_W-1:0]  sel_f_loc;
    logic [FTYPE_W-1:0] sel_f_type;

    s84_rr_arb #(.NREQ(NREQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    always_comb begin
        win_oh     = '0;
        grant_oh   = '0;
        sel_a      = '0;
        sel_b      = '0;
        sel_op     = OP_SQM;
        sel_f_loc  = '0;
        sel_f_type = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            win_oh[i]   = (2'(i) == winner);
            grant_oh[i] = (2'(i) == grant_id);
            if (2'(i) == winner) begin
                sel_a      = req_a[A_W*i +: A_W];
                sel_b      = req_b[B_W*i +: B_W];
                sel_op     = req_op[i];
                sel_f_loc  = req_f_loc[FLOC_W*i +: FLOC_W];
                sel_f_type = req_f_type[FTYPE_W*i +: FTYPE_W];
            end
        end
    end

    // Handshake strobes are masked while reset is high so a discarded op can never be seen.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        done      = 1'b0;
        req_ready = '0;
        rsp_valid = '0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        accept    = 1'b1;
                        req_ready = win_oh;
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        capture   = 1'b1;
                        state_nxt = RESP;
                    end
                end
                RESP: begin
                    rsp_valid = grant_oh;
                    if (|(rsp_ready & grant_oh)) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            last_grant <= 2'(NREQ - 1);
            grant_id   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= OP_SQM;
            alu_f_loc  <= '0;
            alu_f_type <= '0;
            rsp_c      <= '0;
            rsp_y      <= '0;
            rsp_z      <= '0;
            ops_cnt    <= '0;
        end else begin
            if (accept) begin
                alu_a      <= sel_a;
                alu_b      <= sel_b;
                alu_op     <= sel_op;
                alu_f_loc  <= sel_f_loc;
                alu_f_type <= sel_f_type;
                last_grant <= winner;
                grant_id   <= winner;
                cnt        <= 3'(SETTLE - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 3'd1;
            end
            if (capture) begin
                rsp_c <= alu_c;
                rsp_y <= alu_y;
                rsp_z <= alu_z;
            end
            if (done) ops_cnt <= ops_cnt + 16'd1;
        end
    end

    assign busy     = (state != IDLE);
    assign ops_done = ops_cnt;

endmodule

// File: tb/tb_s84_sched.sv
// Bench for s84_sched: a 2-requester/SETTLE=1 instance driven from a vector table and
// hand sequences, plus a 3-requester/SETTLE=3 instance under random traffic vs a model.
module tb_s84_sched;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance with NREQ=2, SETTLE=1
    logic        rst2;
    logic [1:0]  rv2, rdy2, vld2, rr2, gid2;
    logic [15:0] a2, ops2;
    logic [7:0]  b2, c2, y2, aa2, ac2, ay2;
    logic [1:0]  op2;
    logic [5:0]  fl2;
    logic [3:0]  ft2, z2, ab2, az2;
    logic        aop2, busy2, corrupt2;
    logic [2:0]  afl2;
    logic [1:0]  aft2;

    assign ac2 = aa2;
    assign ay2 = corrupt2 ? 8'hEE : (aa2 ^ {4'h0, ab2});
    assign az2 = ab2;

    s84_sched #(.NREQ(2), .SETTLE(1)) dut (
        .clk(clk), .reset(rst2), .req_valid(rv2), .req_ready(rdy2),
        .req_a(a2), .req_b(b2), .req_op(op2), .req_f_loc(fl2), .req_f_type(ft2),
        .rsp_valid(vld2), .rsp_ready(rr2), .rsp_c(c2), .rsp_y(y2), .rsp_z(z2),
        .alu_a(aa2), .alu_b(ab2), .alu_op(aop2), .alu_f_loc(afl2), .alu_f_type(aft2),
        .alu_c(ac2), .alu_y(ay2), .alu_z(az2),
        .busy(busy2), .grant_id(gid2), .ops_done(ops2)
    );

    // instance with NREQ=3, SETTLE=3
    logic        rst3;
    logic [2:0]  rv3, rdy3, vld3, rr3, op3;
    logic [23:0] a3;
    logic [11:0] b3;
    logic [8:0]  fl3;
    logic [5:0]  ft3;
    logic [7:0]  c3, y3, aa3, ac3, ay3;
    logic [3:0]  z3, ab3, az3;
    logic        aop3, busy3, corrupt3;
    logic [2:0]  afl3;
    logic [1:0]  aft3, gid3;
    logic [15:0] ops3;

    assign ac3 = aa3;
    assign ay3 = corrupt3 ? 8'hEE : (aa3 ^ {4'h0, ab3});
    assign az3 = ab3;

    s84_sched #(.NREQ(3), .SETTLE(3)) dut3 (
        .clk(clk), .reset(rst3), .req_valid(rv3), .req_ready(rdy3),
        .req_a(a3), .req_b(b3), .req_op(op3), .req_f_loc(fl3), .req_f_type(ft3),
        .rsp_valid(vld3), .rsp_ready(rr3), .rsp_c(c3), .rsp_y(y3), .rsp_z(z3),
        .alu_a(aa3), .alu_b(ab3), .alu_op(aop3), .alu_f_loc(afl3), .alu_f_type(aft3),
        .alu_c(ac3), .alu_y(ay3), .alu_z(az3),
        .busy(busy3), .grant_id(gid3), .ops_done(ops3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  rv, rr, rdy, vld, gid;
        logic        busy;
        logic [7:0]  alu_a;
        logic [15:0] ops;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] rv, rr, rdy, vld, gid, input logic busy,
                                input logic [7:0] alu_a, input logic [15:0] ops);
        vec_t v;
        v.rv = rv; v.rr = rr; v.rdy = rdy; v.vld = vld; v.gid = gid;
        v.busy = busy; v.alu_a = alu_a; v.ops = ops;
        return v;
    endfunction

    vec_t tbl[18];

    // One full transaction on the 2-requester instance, bounded wait for the response.
    task automatic run_op2(input logic [1:0] rv);
        int n;
        @(negedge clk);
        rv2 = rv; rr2 = 2'b00;
        #1;
        chk("op2_accept", 32'(rdy2), 32'(rv));
        @(negedge clk);
        rv2 = 2'b00;
        n = 0;
        #1;
        while (vld2 == 2'b00 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("op2_rsp_timeout", 32'(n < 20), 32'd1);
        rr2 = 2'b11;
        @(negedge clk);
        rr2 = 2'b00;
    endtask

    // reference-model state for the random phase
    int          lw, t_acc, w, mops;
    bit          pend;
    logic [7:0]  ea;
    logic [3:0]  eb;
    logic [2:0]  efl;
    logic [1:0]  eft;
    logic        eop;

    initial begin
        rst2 = 1'b1; rv2 = '0; rr2 = '0; corrupt2 = 1'b0;
        rst3 = 1'b1; rv3 = '0; rr3 = '0; corrupt3 = 1'b0;
        a2 = {8'hA5, 8'h3C}; b2 = {4'h3, 4'h5}; op2 = 2'b10;
        fl2 = {3'b101, 3'b010}; ft2 = {2'b10, 2'b01};
        a3 = '0; b3 = '0; op3 = '0; fl3 = '0; ft3 = '0;

        tbl[0]  = mk(2'b01, 2'b00, 2'b01, 2'b00, 2'd0, 1'b0, 8'h00, 16'd0);
        tbl[1]  = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'd0, 1'b1, 8'h3C, 16'd0);
        tbl[2]  = mk(2'b11, 2'b00, 2'b00, 2'b01, 2'd0, 1'b1, 8'h3C, 16'd0);
        tbl[3]  = mk(2'b11, 2'b00, 2'b00, 2'b01, 2'd0, 1'b1, 8'h3C, 16'd0);
        tbl[4]  = mk(2'b11, 2'b10, 2'b00, 2'b01, 2'd0, 1'b1, 8'h3C, 16'd0);
        tbl[5]  = mk(2'b11, 2'b00, 2'b00, 2'b01, 2'd0, 1'b1, 8'h3C, 16'd0);
        tbl[6]  = mk(2'b11, 2'b00, 2'b00, 2'b01, 2'd0, 1'b1, 8'h3C, 16'd0);
        tbl[7]  = mk(2'b11, 2'b01, 2'b00, 2'b01, 2'd0, 1'b1, 8'h3C, 16'd0);
        tbl[8]  = mk(2'b11, 2'b11, 2'b10, 2'b00, 2'd0, 1'b0, 8'h3C, 16'd1);
        tbl[9]  = mk(2'b11, 2'b11, 2'b00, 2'b00, 2'd1, 1'b1, 8'hA5, 16'd1);
        tbl[10] = mk(2'b11, 2'b11, 2'b00, 2'b10, 2'd1, 1'b1, 8'hA5, 16'd1);
        tbl[11] = mk(2'b11, 2'b11, 2'b01, 2'b00, 2'd1, 1'b0, 8'hA5, 16'd2);
        tbl[12] = mk(2'b11, 2'b11, 2'b00, 2'b00, 2'd0, 1'b1, 8'h3C, 16'd2);
        tbl[13] = mk(2'b11, 2'b11, 2'b00, 2'b01, 2'd0, 1'b1, 8'h3C, 16'd2);
        tbl[14] = mk(2'b11, 2'b11, 2'b10, 2'b00, 2'd0, 1'b0, 8'h3C, 16'd3);
        tbl[15] = mk(2'b11, 2'b11, 2'b00, 2'b00, 2'd1, 1'b1, 8'hA5, 16'd3);
        tbl[16] = mk(2'b11, 2'b11, 2'b00, 2'b10, 2'd1, 1'b1, 8'hA5, 16'd3);
        tbl[17] = mk(2'b00, 2'b11, 2'b00, 2'b00, 2'd1, 1'b0, 8'hA5, 16'd4);

        // reset state, with a request already pending
        repeat (2) @(negedge clk);
        rv2 = 2'b11;
        #1;
        chk("rst_req_ready", 32'(rdy2), 32'd0);
        chk("rst_rsp_valid", 32'(vld2), 32'd0);
        chk("rst_busy", 32'(busy2), 32'd0);
        chk("rst_grant_id", 32'(gid2), 32'd0);
        chk("rst_ops", 32'(ops2), 32'd0);
        chk("rst_alu", {aa2, ab2, aop2, afl2, aft2, 10'd0}, 32'd0);
        chk("rst_rsp_data", {c2, y2, z2, 12'd0}, 32'd0);
        @(negedge clk);
        rst2 = 1'b0; rv2 = 2'b00;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rv2 = tbl[i].rv; rr2 = tbl[i].rr;
            #1;
            chk($sformatf("tbl%0d_req_ready", i), 32'(rdy2), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_rsp_valid", i), 32'(vld2), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d_grant_id", i), 32'(gid2), 32'(tbl[i].gid));
            chk($sformatf("tbl%0d_busy", i), 32'(busy2), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_alu_a", i), 32'(aa2), 32'(tbl[i].alu_a));
            chk($sformatf("tbl%0d_ops", i), 32'(ops2), 32'(tbl[i].ops));
            if (tbl[i].vld == 2'b01)
                chk($sformatf("tbl%0d_rsp0", i), {c2, y2, z2, 12'd0}, {8'h3C, 8'h39, 4'h5, 12'd0});
            if (tbl[i].vld == 2'b10)
                chk($sformatf("tbl%0d_rsp1", i), {c2, y2, z2, 12'd0}, {8'hA5, 8'hA6, 4'h3, 12'd0});
            if (tbl[i].busy && tbl[i].gid == 2'd0)
                chk($sformatf("tbl%0d_alu_ctl0", i), {ab2, aop2, afl2, aft2}, {4'h5, 1'b0, 3'b010, 2'b01});
            if (tbl[i].busy && tbl[i].gid == 2'd1)
                chk($sformatf("tbl%0d_alu_ctl1", i), {ab2, aop2, afl2, aft2}, {4'h3, 1'b1, 3'b101, 2'b10});
        end

        // reset while WAIT: op discarded, requester 0 wins first afterwards
        @(negedge clk);
        rv2 = 2'b01; rr2 = 2'b00;
        #1;
        chk("mid_accept", 32'(rdy2), 32'b01);
        @(negedge clk);
        rv2 = 2'b00;
        #1;
        chk("mid_in_wait", 32'(busy2), 32'd1);
        rst2 = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_busy", 32'(busy2), 32'd0);
        chk("mid_rst_outs", {vld2, rdy2, gid2, aa2, y2}, 32'd0);
        chk("mid_rst_ops", 32'(ops2), 32'd0);
        rst2 = 1'b0; rr2 = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            chk("mid_no_rsp", 32'(vld2), 32'd0);
        end
        rv2 = 2'b11; rr2 = 2'b00;
        #1;
        chk("mid_first_winner", 32'(rdy2), 32'b01);
        rv2 = 2'b00;
        run_op2(2'b10);
        #1;
        chk("mid_ops_after", 32'(ops2), 32'd1);

        // counter wrap
        @(negedge clk);
        force dut.ops_cnt = 16'hFFFF;
        #1;
        release dut.ops_cnt;
        #1;
        chk("wrap_preload", 32'(ops2), 32'hFFFF);
        run_op2(2'b01);
        #1;
        chk("wrap_zero", 32'(ops2), 32'd0);

        // SETTLE=3: response at t+4, stub corrupted during t+1..t+2
        @(negedge clk);
        rst3 = 1'b0;
        a3 = {8'h11, 8'h22, 8'h5A}; b3 = {4'h1, 4'h2, 4'hC};
        rv3 = 3'b001;
        #1;
        chk("s3_accept", 32'(rdy3), 32'b001);
        @(negedge clk);
        rv3 = 3'b000; corrupt3 = 1'b1;
        #1;
        chk("s3_t1_vld", 32'(vld3), 32'd0);
        chk("s3_t1_alu_a", 32'(aa3), 32'h5A);
        @(negedge clk); #1;
        chk("s3_t2_vld", 32'(vld3), 32'd0);
        corrupt3 = 1'b0;
        @(negedge clk); #1;
        chk("s3_t3_vld", 32'(vld3), 32'd0);
        @(negedge clk); #1;
        chk("s3_t4_vld", 32'(vld3), 32'b001);
        chk("s3_t4_rsp", {c3, y3, z3, 12'd0}, {8'h5A, 8'h56, 4'hC, 12'd0});
        rr3 = 3'b001;
        @(negedge clk);
        rr3 = 3'b000;
        #1;
        chk("s3_ops", 32'(ops3), 32'd1);

        // random traffic against a transaction-level model
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        lw = 2; pend = 1'b0; mops = 0; t_acc = 0; w = 0;
        ea = '0; eb = '0; efl = '0; eft = '0; eop = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic [2:0] exp_rdy, exp_vld;
            @(negedge clk);
            rv3 = 3'($urandom_range(0, 7));
            rr3 = 3'($urandom);
            a3 = 24'($urandom); b3 = 12'($urandom); op3 = 3'($urandom);
            fl3 = 9'($urandom); ft3 = 6'($urandom);
            #1;
            exp_rdy = '0; exp_vld = '0;
            chk("rnd_busy", 32'(busy3), 32'(pend));
            chk("rnd_ops", 32'(ops3), 32'(mops[15:0]));
            if (!pend) begin
                for (int k = 1; k <= 3; k++) begin
                    int idx;
                    idx = (lw + k) % 3;
                    if (!pend && rv3[idx]) begin
                        pend = 1'b1; exp_rdy[idx] = 1'b1; t_acc = n; w = idx; lw = idx;
                        ea = a3[8*idx +: 8]; eb = b3[4*idx +: 4]; eop = op3[idx];
                        efl = fl3[3*idx +: 3]; eft = ft3[2*idx +: 2];
                    end
                end
            end else if (n - t_acc <= 3) begin
                chk("rnd_alu", {aa3, ab3, aop3, afl3, aft3}, {ea, eb, eop, efl, eft});
                chk("rnd_gid", 32'(gid3), 32'(w));
            end else begin
                exp_vld[w] = 1'b1;
                chk("rnd_rsp", {c3, y3, z3}, {ea, ea ^ {4'h0, eb}, eb});
                if (rr3[w]) begin
                    mops++;
                    pend = 1'b0;
                end
            end
            chk("rnd_req_ready", 32'(rdy3), 32'(exp_rdy));
            chk("rnd_rsp_valid", 32'(vld3), 32'(exp_vld));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
